// File: rtl/spi_mem_pkg.sv
// Shared encodings for the SPI memory command engine: command codes and FSM states.
package spi_mem_pkg;

   typedef enum logic [1:0] {
      CMD_SET_WADDR = 2'b00,
      CMD_WRITE     = 2'b01,
      CMD_SET_RADDR = 2'b10,
      CMD_READ      = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND
   } state_e;

endpackage

// File: rtl/spi_mem_ram.sv
// Single-port synchronous RAM with registered read; a write wins over a read in the same cycle.
module spi_mem_ram
   import spi_mem_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end else if (re) begin
         q <= mem[addr];
      end
   end

endmodule

// File: rtl/spi_burst_mem.sv
// SPI-side memory command engine: decodes {cmd,payload} words, keeps write/read pointers
// and streams burst reads out through a ready/valid output register.
module spi_burst_mem
   import spi_mem_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [DATA_W+1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [DATA_W:0]   DEPTH_X   = (DATA_W + 1)'(MEM_DEPTH);

   state_e            state, state_nx;
   cmd_e              cmd;
   logic [DATA_W-1:0] payload;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [DATA_W-1:0] cnt;
   logic              accept, in_range, handshake;
   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_q;

   function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
   endfunction

   assign cmd       = cmd_e'(din[DATA_W+1:DATA_W]);
   assign payload   = din[DATA_W-1:0];
   // accept is decoded from state directly so it does not loop through the output process
   assign accept    = rx_valid && (state == IDLE);
   assign in_range  = {1'b0, payload} < DEPTH_X;
   assign handshake = tx_valid && tx_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept && cmd == CMD_READ) state_nx = FETCH;
         FETCH:   state_nx = SEND;
         SEND:    if (handshake) state_nx = (cnt == '0) ? IDLE : FETCH;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      rx_ready = (state == IDLE);
      busy     = (state != IDLE);
      ram_we   = accept && (cmd == CMD_WRITE);
      ram_re   = (state == FETCH);
      ram_addr = (state == FETCH) ? rd_ptr : wr_ptr;
   end

   // SEND spends its first cycle loading dout from the RAM, then holds it until the handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         dout     <= '0;
         tx_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         if (accept) begin
            case (cmd)
               CMD_SET_WADDR: begin
                  if (in_range) wr_ptr <= payload[ADDR_W-1:0];
                  else          err    <= 1'b1;
               end
               CMD_WRITE:     wr_ptr <= bump(wr_ptr);
               CMD_SET_RADDR: begin
                  if (in_range) rd_ptr <= payload[ADDR_W-1:0];
                  else          err    <= 1'b1;
               end
               CMD_READ:      cnt <= payload;
               default:       ;
            endcase
         end
         if (state == SEND) begin
            if (!tx_valid) begin
               dout     <= ram_q;
               tx_valid <= 1'b1;
            end else if (tx_ready) begin
               tx_valid <= 1'b0;
               rd_ptr   <= bump(rd_ptr);
               cnt      <= cnt - DATA_W'(1);
            end
         end
      end
   end

   spi_mem_ram #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .MEM_DEPTH(MEM_DEPTH)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .re   (ram_re),
      .addr (ram_addr),
      .wdata(payload),
      .q    (ram_q)
   );

endmodule
